fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage_pc_reg.sv | 25 ++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ==========================================================================
// fetch_stage_pkg : shared types and constants for the instruction fetch stage
// Revision 1.0
// ==========================================================================
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          OPCODE_W  = 5;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ==========================================================================
// fetch_stage_if : instruction memory, pipeline control and IF/ID signals
// Revision 1.0
// ==========================================================================
interface fetch_stage_if;

    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_dec;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic        err;

    modport master (
        output imem_addr, imem_en, instr, pc_plus2, instr_valid, halted, err,
        input  imem_data, imem_ready, stall, redirect_valid, redirect_pc, halt_dec
    );

    modport slave (
        input  imem_addr, imem_en, instr, pc_plus2, instr_valid, halted, err,
        output imem_data, imem_ready, stall, redirect_valid, redirect_pc, halt_dec
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// ==========================================================================
// pc_reg : 16-bit program counter register with write enable
// Revision 1.0
// ==========================================================================
module pc_reg
    import fetch_stage_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        we_i,
    input  wire logic [15:0] d_i,
    output logic      [15:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RESET_PC;
        end else if (we_i) begin
            q_o <= d_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ==========================================================================
// fetch_stage : PC sequencing, imem handshake and IF/ID register
// Revision 1.0
// ==========================================================================
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.master fs_if
);

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  pc_d;
    logic         pc_we;
    logic [15:0]  pc_inc;
    logic [15:0]  instr_q;
    logic [15:0]  pc_plus2_q;
    logic [15:0]  pend_q;
    logic         instr_valid_q;
    logic         halted_q;
    logic         pend_valid_q;

    // One-hot decision flags shared by the PC mux and the state register
    logic redir_now;
    logic pend_now;
    logic pend_store;
    logic capture;
    logic miss;
    logic halt_now;

    assign pc_inc = pc_q + 16'd2;

    always_comb begin
        redir_now  = 1'b0;
        pend_now   = 1'b0;
        pend_store = 1'b0;
        capture    = 1'b0;
        miss       = 1'b0;
        halt_now   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fs_if.redirect_valid) begin
                    redir_now = 1'b1;
                end else if (fs_if.halt_dec && instr_valid_q) begin
                    halt_now = 1'b1;
                end else if (!fs_if.stall) begin
                    capture = fs_if.imem_ready;
                    miss    = !fs_if.imem_ready;
                end
            end
            ST_WAIT: begin
                // A pending redirect resolves even under stall; it wins like a live redirect
                if (fs_if.redirect_valid) begin
                    redir_now  = fs_if.imem_ready;
                    pend_store = !fs_if.imem_ready;
                end else if (fs_if.imem_ready) begin
                    pend_now = pend_valid_q;
                    capture  = !pend_valid_q && !fs_if.stall;
                end
            end
            default: ;
        endcase
    end

    assign pc_we = redir_now | pend_now | capture;
    assign pc_d  = redir_now ? fs_if.redirect_pc :
                   pend_now  ? pend_q             : pc_inc;

    pc_reg u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .we_i (pc_we),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            instr_q       <= NOP_INSTR;
            pc_plus2_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            pend_q        <= RESET_PC;
            pend_valid_q  <= 1'b0;
        end else begin
            if (redir_now || pend_now || miss || halt_now) begin
                instr_q       <= NOP_INSTR;
                instr_valid_q <= 1'b0;
            end
            if (capture) begin
                instr_q       <= fs_if.imem_data;
                pc_plus2_q    <= pc_inc;
                instr_valid_q <= 1'b1;
            end
            if (redir_now || pend_now || capture) begin
                state_q <= ST_RUN;
            end
            if (redir_now || pend_now) begin
                pend_valid_q <= 1'b0;
            end
            if (pend_store) begin
                pend_q       <= fs_if.redirect_pc;
                pend_valid_q <= 1'b1;
            end
            if (miss) begin
                state_q <= ST_WAIT;
            end
            if (halt_now) begin
                state_q  <= ST_HALTED;
                halted_q <= 1'b1;
            end
        end
    end

    assign fs_if.imem_addr   = pc_q;
    assign fs_if.imem_en     = (state_q != ST_HALTED);
    assign fs_if.instr       = instr_q;
    assign fs_if.pc_plus2    = pc_plus2_q;
    assign fs_if.instr_valid = instr_valid_q;
    assign fs_if.halted      = halted_q;
    assign fs_if.err         = pc_q[0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ==========================================================================
// tb_fetch_stage : directed stimulus with a behavioural fetch model
// Revision 1.0
// ==========================================================================
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en = 1'b0;

    fetch_stage_if fif ();

    fetch_stage dut (
        .clk   (clk),
        .rst   (rst),
        .fs_if (fif.master)
    );

    always #5 clk = ~clk;

    // Behavioural model: fetch pointer, IF/ID contents and a pending-target slot
    logic [15:0] m_pc, m_instr, m_pp2, m_pend;
    logic        m_valid, m_halted, m_waiting, m_pend_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 16'h0; m_instr <= NOP; m_pp2 <= 16'h0; m_valid <= 1'b0;
            m_halted <= 1'b0; m_waiting <= 1'b0; m_pend <= 16'h0; m_pend_v <= 1'b0;
        end else if (m_halted) begin
            m_halted <= 1'b1;
        end else if (!m_waiting) begin
            if (fif.redirect_valid) begin
                m_pc <= fif.redirect_pc; m_instr <= NOP; m_valid <= 1'b0;
            end else if (fif.halt_dec && m_valid) begin
                m_halted <= 1'b1; m_instr <= NOP; m_valid <= 1'b0;
            end else if (!fif.stall) begin
                if (fif.imem_ready) begin
                    m_instr <= fif.imem_data; m_pp2 <= m_pc + 16'd2;
                    m_valid <= 1'b1; m_pc <= m_pc + 16'd2;
                end else begin
                    m_instr <= NOP; m_valid <= 1'b0; m_waiting <= 1'b1;
                end
            end
        end else begin
            if (fif.redirect_valid && fif.imem_ready) begin
                m_pc <= fif.redirect_pc; m_waiting <= 1'b0; m_pend_v <= 1'b0;
            end else if (fif.redirect_valid) begin
                m_pend <= fif.redirect_pc; m_pend_v <= 1'b1;
            end else if (fif.imem_ready && m_pend_v) begin
                m_pc <= m_pend; m_pend_v <= 1'b0; m_waiting <= 1'b0;
            end else if (fif.imem_ready && !fif.stall) begin
                m_instr <= fif.imem_data; m_pp2 <= m_pc + 16'd2;
                m_valid <= 1'b1; m_pc <= m_pc + 16'd2; m_waiting <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model imem_addr",   fif.imem_addr, m_pc);
            chk("model imem_en",     {15'd0, fif.imem_en}, {15'd0, !m_halted});
            chk("model instr",       fif.instr, m_instr);
            chk("model pc_plus2",    fif.pc_plus2, m_pp2);
            chk("model instr_valid", {15'd0, fif.instr_valid}, {15'd0, m_valid});
            chk("model halted",      {15'd0, fif.halted}, {15'd0, m_halted});
            chk("model err",         {15'd0, fif.err}, {15'd0, m_pc[0]});
        end
    end

    task automatic cyc(input logic rdy, input logic [15:0] data, input logic stl,
                       input logic rv, input logic [15:0] rpc, input logic hd);
        fif.imem_ready     = rdy;
        fif.imem_data      = data;
        fif.stall          = stl;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        fif.halt_dec       = hd;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        fif.imem_ready = 1'b0; fif.imem_data = 16'h0; fif.stall = 1'b0;
        fif.redirect_valid = 1'b0; fif.redirect_pc = 16'h0; fif.halt_dec = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset addr",   fif.imem_addr, 16'h0000);
        chk("reset instr",  fif.instr, 16'h0800);
        chk("reset pp2",    fif.pc_plus2, 16'h0000);
        chk("reset valid",  {15'd0, fif.instr_valid}, 16'd0);
        chk("reset halted", {15'd0, fif.halted}, 16'd0);
        chk("reset en",     {15'd0, fif.imem_en}, 16'd1);
        rst = 1'b0;

        // Streaming fetch
        cyc(1, 16'h1000, 0, 0, 0, 0);
        chk("stream addr1", fif.imem_addr, 16'h0002);
        chk("stream pp2_1", fif.pc_plus2, 16'h0002);
        chk("stream valid", {15'd0, fif.instr_valid}, 16'd1);
        cyc(1, 16'h1001, 0, 0, 0, 0);
        chk("stream addr2", fif.imem_addr, 16'h0004);
        chk("stream pp2_2", fif.pc_plus2, 16'h0004);
        for (int i = 0; i < 6; i++) cyc(1, 16'h1002 + 16'(i), 0, 0, 0, 0);
        chk("stream at 0x10", fif.imem_addr, 16'h0010);

        // Memory not ready for two cycles
        cyc(0, 16'hAAAA, 0, 0, 0, 0);
        chk("miss1 valid", {15'd0, fif.instr_valid}, 16'd0);
        cyc(0, 16'hAAAA, 0, 0, 0, 0);
        chk("miss2 instr", fif.instr, 16'h0800);
        chk("miss2 addr",  fif.imem_addr, 16'h0010);
        cyc(1, 16'h4123, 0, 0, 0, 0);
        chk("miss capture", fif.instr, 16'h4123);
        chk("miss pp2",     fif.pc_plus2, 16'h0012);

        // Stall holds IF/ID and PC
        for (int i = 0; i < 3; i++) cyc(1, 16'hDEAD, 1, 0, 0, 0);
        chk("stall instr", fif.instr, 16'h4123);
        chk("stall addr",  fif.imem_addr, 16'h0012);
        cyc(1, 16'h2222, 0, 0, 0, 0);
        chk("unstall instr", fif.instr, 16'h2222);
        chk("unstall addr",  fif.imem_addr, 16'h0014);

        // Stall while waiting: returned word discarded and re-fetched
        cyc(0, 16'h0, 0, 0, 0, 0);
        cyc(1, 16'h5555, 1, 0, 0, 0);
        chk("wait stall addr", fif.imem_addr, 16'h0014);
        cyc(1, 16'h6666, 0, 0, 0, 0);
        chk("wait refetch", fif.instr, 16'h6666);

        // Redirect beats stall and halt_dec
        cyc(1, 16'h7777, 1, 1, 16'h0100, 1);
        chk("redir addr",   fif.imem_addr, 16'h0100);
        chk("redir valid",  {15'd0, fif.instr_valid}, 16'd0);
        chk("redir halted", {15'd0, fif.halted}, 16'd0);

        // Two redirects while waiting: youngest wins
        cyc(0, 16'h0, 0, 0, 0, 0);
        cyc(0, 16'h0, 0, 1, 16'h0200, 0);
        cyc(0, 16'h0, 0, 1, 16'h0300, 0);
        cyc(1, 16'hBEEF, 0, 0, 0, 0);
        chk("pend addr",  fif.imem_addr, 16'h0300);
        chk("pend drop",  fif.instr, 16'h0800);
        cyc(1, 16'h3333, 0, 0, 0, 0);
        chk("pend fetch", fif.instr, 16'h3333);
        chk("pend pp2",   fif.pc_plus2, 16'h0302);

        // Misaligned PC and wrap
        cyc(1, 16'h0, 0, 1, 16'h0301, 0);
        chk("err set", {15'd0, fif.err}, 16'd1);
        cyc(1, 16'h1234, 0, 0, 0, 0);
        chk("err fetch", fif.imem_addr, 16'h0303);
        cyc(1, 16'h0, 0, 1, 16'hFFFE, 0);
        cyc(1, 16'h4321, 0, 0, 0, 0);
        chk("wrap addr", fif.imem_addr, 16'h0000);
        chk("wrap pp2",  fif.pc_plus2, 16'h0000);

        // Halt
        cyc(1, 16'h0, 0, 1, 16'h001E, 0);
        cyc(1, 16'hF800, 0, 0, 0, 0);
        cyc(1, 16'h9999, 0, 0, 0, 1);
        chk("halt flag", {15'd0, fif.halted}, 16'd1);
        chk("halt en",   {15'd0, fif.imem_en}, 16'd0);
        chk("halt addr", fif.imem_addr, 16'h0020);
        cyc(1, 16'h0, 0, 1, 16'h0400, 0);
        cyc(0, 16'h0, 1, 0, 0, 0);
        chk("halt sticky", fif.imem_addr, 16'h0020);
        rst = 1'b1;
        #1;
        chk("async halted", {15'd0, fif.halted}, 16'd0);
        chk("async addr",   fif.imem_addr, 16'h0000);
        cyc(1, 16'h0, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset in WAIT with a pending redirect
        cyc(1, 16'h1111, 0, 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 0, 0);
        cyc(0, 16'h0, 0, 1, 16'h0500, 0);
        rst = 1'b1;
        #1;
        chk("wait rst addr", fif.imem_addr, 16'h0000);
        cyc(0, 16'h0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, 16'h7777, 0, 0, 0, 0);
        chk("post rst instr", fif.instr, 16'h7777);
        chk("post rst addr",  fif.imem_addr, 16'h0002);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
